// File: rtl/im_load_mem_if.sv
// Bus bundle for the loadable instruction memory: fetch port plus program-load
// handshake. The memory takes the slave side; the core/loader takes the master side.
interface im_load_mem_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 5
);
  // Fetch port
  logic [ADDR_W-1:0]   iaddr;
  logic                fetch_req;
  logic [DATA_W-1:0]   idata;
  logic                idata_valid;
  logic                addr_err;
  // Program-load port
  logic                ld_start;
  logic                ld_valid;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_last;
  logic                ld_ready;
  logic                ld_done;
  logic [DEPTH_LOG2:0] ld_count;
  logic                busy;

  modport slave (
    input  iaddr, fetch_req, ld_start, ld_valid, ld_data, ld_last,
    output idata, idata_valid, addr_err, ld_ready, ld_done, ld_count, busy
  );

  modport master (
    output iaddr, fetch_req, ld_start, ld_valid, ld_data, ld_last,
    input  idata, idata_valid, addr_err, ld_ready, ld_done, ld_count, busy
  );
endinterface

// File: rtl/im_load_mem.sv
// Loadable instruction memory for the 16-bit LEGv8-style core. A program is
// streamed in over the ld_* handshake; the fetch port then reads it back with a
// registered one-cycle latency. Words past the loaded length read DEFAULT_WORD.
module im_load_mem #(
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH_LOG2   = 5,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
  input logic          clock,
  input logic          reset,
  im_load_mem_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IDX_W = ADDR_W - 1;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    ld_count_q, ld_count_d;
  logic [DATA_W-1:0]   idata_q, idata_d;
  logic                idata_valid_q, idata_valid_d;
  logic                addr_err_q, addr_err_d;
  logic                ld_ready_q, ld_ready_d;
  logic                ld_done_q, ld_done_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    word_idx;
  logic                in_range;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_iaddr_lsb;

  // Word index from the byte address; the byte-select bit plays no part.
  assign word_idx         = bus.iaddr[ADDR_W-1:1];
  assign unused_iaddr_lsb = bus.iaddr[0];

  // A word is reachable only if it is inside the array and inside the loaded image.
  assign in_range = (word_idx < IDX_W'(DEPTH)) && (word_idx < IDX_W'(ld_count_q));
  assign rd_word  = mem[word_idx[DEPTH_LOG2-1:0]];
  assign wr_en    = (state_q == ST_LOAD) && bus.ld_valid && ld_ready_q;

  // Program storage write port.
  // NOTE: the array has no reset; ld_count gates every read, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (wr_en) mem[ptr_q] <= bus.ld_data;
  end

  // Next-state and next-output logic for the RUN/LOAD/DONE controller.
  // NOTE: every _d gets its hold/default value first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    ld_count_d    = ld_count_q;
    idata_d       = idata_q;
    addr_err_d    = addr_err_q;
    idata_valid_d = 1'b0;
    ld_done_d     = 1'b0;
    ld_ready_d    = ld_ready_q;
    busy_d        = busy_q;

    case (state_q)
      ST_RUN: begin
        // A fetch in the same cycle as ld_start still sees the old image.
        if (bus.fetch_req) begin
          idata_d       = in_range ? rd_word : DEFAULT_WORD;
          addr_err_d    = !in_range;
          idata_valid_d = 1'b1;
        end
        if (bus.ld_start) begin
          state_d    = ST_LOAD;
          ptr_d      = '0;
          ld_count_d = '0;
          busy_d     = 1'b1;
          ld_ready_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          ptr_d = ptr_q + DEPTH_LOG2'(1);
          // ld_last and a full array are one and the same exit.
          if (bus.ld_last || (ptr_q == DEPTH_LOG2'(DEPTH - 1))) begin
            state_d    = ST_DONE;
            ld_count_d = CNT_W'(ptr_q) + CNT_W'(1);
            ld_ready_d = 1'b0;
            busy_d     = 1'b0;
            ld_done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Controller state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      ptr_q         <= '0;
      ld_count_q    <= '0;
      idata_q       <= DEFAULT_WORD;
      idata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ld_count_q    <= ld_count_d;
      idata_q       <= idata_d;
      idata_valid_q <= idata_valid_d;
      addr_err_q    <= addr_err_d;
      ld_ready_q    <= ld_ready_d;
      ld_done_q     <= ld_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.idata       = idata_q;
  assign bus.idata_valid = idata_valid_q;
  assign bus.addr_err    = addr_err_q;
  assign bus.ld_ready    = ld_ready_q;
  assign bus.ld_done     = ld_done_q;
  assign bus.ld_count    = ld_count_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_im_load_mem.sv
// Scoreboard bench for im_load_mem: stimulus pushes expected fetch results from a
// simple array model; a monitor pops and compares on every idata_valid pulse.
module tb_im_load_mem;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int DEPTH_LOG2 = 5;
  localparam int DEPTH      = 32;
  localparam logic [15:0] DEF_WORD = 16'h0000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  im_load_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  im_load_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .DEFAULT_WORD(DEF_WORD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } fetch_exp_t;

  fetch_exp_t  exp_q[$];
  logic [15:0] model_mem [DEPTH];
  int          model_count = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the image is model_mem[0 .. model_count-1]; anything else is an error read.
  function automatic fetch_exp_t model_fetch(input logic [15:0] a);
    fetch_exp_t r;
    int w;
    w = int'(a) / 2;
    if (w >= DEPTH || w >= model_count) begin
      r.data = DEF_WORD;
      r.err  = 1'b1;
    end else begin
      r.data = model_mem[w];
      r.err  = 1'b0;
    end
    return r;
  endfunction

  // Monitor: every idata_valid pulse must match the oldest outstanding fetch.
  always @(negedge clock) begin : monitor
    fetch_exp_t e;
    if (!reset && bus.idata_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_idata_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("idata", 32'(bus.idata), 32'(e.data));
        check("addr_err", 32'(bus.addr_err), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.iaddr     = '0;
    bus.fetch_req = 1'b0;
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a);
    @(negedge clock);
    bus.iaddr     = a;
    bus.fetch_req = 1'b1;
    exp_q.push_back(model_fetch(a));
    @(negedge clock);
    bus.fetch_req = 1'b0;
  endtask

  task automatic random_fetches(input int n);
    for (int i = 0; i < n; i++) fetch(16'($urandom_range(0, 16'h0050)));
  endtask

  task automatic drain();
    repeat (2) @(negedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Streams prog in; optionally fetches fa in the ld_start cycle and inserts
  // random idle cycles. Fetch/ld_start noise during LOAD must have no effect.
  task automatic load(input logic [15:0] prog[$], input bit use_last,
                      input bit fetch_at_start, input logic [15:0] fa, input bit rand_gaps);
    int n;
    int gaps;
    n = prog.size();
    @(negedge clock);
    bus.ld_start = 1'b1;
    if (fetch_at_start) begin
      bus.iaddr     = fa;
      bus.fetch_req = 1'b1;
      exp_q.push_back(model_fetch(fa));
    end
    @(negedge clock);
    bus.ld_start  = 1'b0;
    bus.fetch_req = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("ld_ready_after_start", 32'(bus.ld_ready), 32'd1);
    check("ld_count_cleared", 32'(bus.ld_count), 32'd0);
    for (int i = 0; i < n; i++) begin
      gaps = 0;
      while (rand_gaps && gaps < 6 && $urandom_range(0, 1) == 1) begin
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 16'($urandom);
        bus.ld_last   = 1'($urandom);
        bus.fetch_req = 1'($urandom);
        bus.iaddr     = 16'($urandom_range(0, 16'h0040));
        bus.ld_start  = 1'($urandom);
        gaps++;
        @(negedge clock);
      end
      check("ld_ready_in_load", 32'(bus.ld_ready), 32'd1);
      bus.ld_valid  = 1'b1;
      bus.ld_data   = prog[i];
      bus.ld_last   = use_last && (i == n - 1);
      bus.fetch_req = 1'($urandom);
      bus.iaddr     = 16'($urandom_range(0, 16'h0040));
      bus.ld_start  = 1'($urandom);
      @(negedge clock);
    end
    model_count = n;
    for (int i = 0; i < n; i++) model_mem[i] = prog[i];
    // DONE cycle: pulse visible, handshake closed; a fetch and a stray word are both ignored.
    check("ld_done_pulse", 32'(bus.ld_done), 32'd1);
    check("busy_in_done", 32'(bus.busy), 32'd0);
    check("ld_ready_in_done", 32'(bus.ld_ready), 32'd0);
    check("ld_count_done", 32'(bus.ld_count), 32'(n));
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b1;
    bus.ld_data   = 16'hDEAD;
    bus.ld_last   = 1'b0;
    bus.fetch_req = 1'b1;
    bus.iaddr     = 16'h0000;
    @(negedge clock);
    check("ld_done_one_cycle", 32'(bus.ld_done), 32'd0);
    check("ld_ready_after_done", 32'(bus.ld_ready), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("ld_count_hold", 32'(bus.ld_count), 32'(n));
    idle_inputs();
  endtask

  initial begin : stimulus
    logic [15:0] prog[$];

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_idata", 32'(bus.idata), 32'(DEF_WORD));
    check("rst_idata_valid", 32'(bus.idata_valid), 32'd0);
    check("rst_addr_err", 32'(bus.addr_err), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_ld_done", 32'(bus.ld_done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ld_count", 32'(bus.ld_count), 32'd0);

    // Empty memory: every fetch is an error read.
    fetch(16'h0000);
    drain();

    // Nine-word program terminated by ld_last.
    prog = {};
    prog.push_back(16'hC1E3);
    prog.push_back(16'h6003);
    for (int i = 2; i < 9; i++) prog.push_back(16'($urandom));
    load(prog, 1'b1, 1'b0, 16'h0000, 1'b0);
    fetch(16'h0004);
    fetch(16'h0012);
    fetch(16'h0010);
    fetch(16'h0011);
    random_fetches(8);
    drain();

    // Full 32-word program with no ld_last; exit on the last slot.
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(16'($urandom));
    load(prog, 1'b0, 1'b0, 16'h0000, 1'b0);
    fetch(16'h003E);
    fetch(16'h0040);
    fetch(16'h0000);
    fetch(16'hFFFE);
    random_fetches(8);
    drain();

    // Start overlapping a fetch of the old image, gappy 5-word reload.
    prog = {};
    for (int i = 0; i < 5; i++) prog.push_back(16'($urandom));
    load(prog, 1'b1, 1'b1, 16'h0002, 1'b1);
    for (int i = 0; i < 6; i++) fetch(16'(2 * i));
    fetch(16'h003E);
    random_fetches(6);
    drain();

    // Full memory with ld_last on the final word: one exit, count of 32.
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(16'($urandom));
    load(prog, 1'b1, 1'b0, 16'h0000, 1'b0);
    fetch(16'h003E);
    fetch(16'h0020);
    drain();

    // Reset in the middle of a load.
    @(negedge clock);
    bus.ld_start = 1'b1;
    @(negedge clock);
    bus.ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'($urandom);
      @(negedge clock);
    end
    bus.ld_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midload_rst_busy", 32'(bus.busy), 32'd0);
    check("midload_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("midload_rst_ld_count", 32'(bus.ld_count), 32'd0);
    model_count = 0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("post_rst_ld_count", 32'(bus.ld_count), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    fetch(16'h0000);
    fetch(16'h0006);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
